// File: rtl/code_store_responder_pkg.sv
// Shared constants and FSM encoding for the command-store responder and its RAM.
package code_store_responder_pkg;

    localparam int DEF_LEN_SEGMENT = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RWAIT   = 3'd1,
        ST_DRIVE   = 3'd2,
        ST_WCAP    = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    // Bits needed to index n items; never returns zero.
    function automatic int bits_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/code_store_ram.sv
// Single-port command store: synchronous write, registered read of the same address.
module code_store_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int W     = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/code_store_responder.sv
// Fabric slave answering command fetch/store transactions over the four shared segment lanes.
// Handshake: master holds BUSY_line_MASTER for the whole transaction; we raise BUSY_line_SLAVE while working.
module code_store_responder
    import code_store_responder_pkg::*;
#(
    parameter int LEN_SEGMENT = DEF_LEN_SEGMENT,
    parameter int DEPTH       = 2**LEN_SEGMENT,
    parameter int RD_LAT      = 1
) (
    input  logic                   CLK_B,
    input  logic                   RESET,
    input  logic                   SEL,
    input  logic                   ADDR,
    input  logic                   READ,
    input  logic                   WRITE,
    input  logic                   BUSY_line_MASTER,
    output logic                   BUSY_line_SLAVE,
    inout  wire  [LEN_SEGMENT-1:0] SA_D3,
    inout  wire  [LEN_SEGMENT-1:0] SB_D2,
    inout  wire  [LEN_SEGMENT-1:0] SC_D1,
    inout  wire  [LEN_SEGMENT-1:0] IP_D0,
    output logic                   ERR,
    output state_t                 state_dbg
);

    localparam int CMD_W  = 4 * LEN_SEGMENT;
    localparam int RAM_AW = bits_for(DEPTH);
    localparam int CNT_W  = bits_for(RD_LAT);
    localparam logic [LEN_SEGMENT:0] DEPTH_L  = (LEN_SEGMENT+1)'(DEPTH);
    localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(RD_LAT - 1);

    state_t                 state;
    logic [LEN_SEGMENT-1:0] addr_q;
    logic                   addr_ok_q;
    logic [CNT_W-1:0]       cnt;
    logic [LEN_SEGMENT-1:0] cur_addr;
    logic [RAM_AW-1:0]      ram_addr;
    logic [CMD_W-1:0]       rdata;
    logic [CMD_W-1:0]       lane_word;
    logic [CMD_W-1:0]       drive_word;
    logic                   start;
    logic                   cur_ok;
    logic                   ram_we;
    logic                   lane_oe;

    assign lane_word = {SA_D3, SB_D2, SC_D1, IP_D0};
    assign start     = SEL & BUSY_line_MASTER & ADDR;
    assign cur_ok    = {1'b0, IP_D0} < DEPTH_L;

    // The RAM sees the live address lane in IDLE so the read is issued on the address-phase edge.
    assign cur_addr  = (state == ST_IDLE) ? IP_D0 : addr_q;
    assign ram_addr  = RAM_AW'(cur_addr);
    assign ram_we    = (state == ST_WCAP) && BUSY_line_MASTER && WRITE && !ADDR && addr_ok_q;

    // Lane enable decodes the state register, so RESET releases the lanes without an edge.
    assign lane_oe    = (state == ST_DRIVE);
    assign drive_word = addr_ok_q ? rdata : '0;
    assign SA_D3 = lane_oe ? drive_word[4*LEN_SEGMENT-1 -: LEN_SEGMENT] : 'z;
    assign SB_D2 = lane_oe ? drive_word[3*LEN_SEGMENT-1 -: LEN_SEGMENT] : 'z;
    assign SC_D1 = lane_oe ? drive_word[2*LEN_SEGMENT-1 -: LEN_SEGMENT] : 'z;
    assign IP_D0 = lane_oe ? drive_word[LEN_SEGMENT-1 -: LEN_SEGMENT]   : 'z;

    assign state_dbg = state;

    code_store_ram #(
        .DEPTH (DEPTH),
        .AW    (RAM_AW),
        .W     (CMD_W)
    ) u_ram (
        .clk   (CLK_B),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (lane_word),
        .rdata (rdata)
    );

    always_ff @(posedge CLK_B or posedge RESET) begin
        if (RESET) begin
            state           <= ST_IDLE;
            BUSY_line_SLAVE <= 1'b0;
            ERR             <= 1'b0;
            cnt             <= '0;
            addr_q          <= '0;
            addr_ok_q       <= 1'b0;
        end else begin
            ERR <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr_q    <= IP_D0;
                        addr_ok_q <= cur_ok;
                        if (READ && WRITE) begin
                            ERR   <= 1'b1;
                            state <= ST_RELEASE;
                        end else if (READ) begin
                            cnt             <= CNT_LOAD;
                            BUSY_line_SLAVE <= 1'b1;
                            state           <= ST_RWAIT;
                        end else if (WRITE) begin
                            BUSY_line_SLAVE <= 1'b1;
                            state           <= ST_WCAP;
                        end
                    end
                end
                ST_RWAIT: begin
                    if (!BUSY_line_MASTER) begin
                        BUSY_line_SLAVE <= 1'b0;
                        state           <= ST_IDLE;
                    end else if (cnt == '0) begin
                        BUSY_line_SLAVE <= 1'b0;
                        ERR             <= !addr_ok_q;
                        state           <= ST_DRIVE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_DRIVE: begin
                    if (!BUSY_line_MASTER) begin
                        state <= ST_IDLE;
                    end
                end
                ST_WCAP: begin
                    if (!BUSY_line_MASTER) begin
                        BUSY_line_SLAVE <= 1'b0;
                        state           <= ST_IDLE;
                    end else if (WRITE && !ADDR) begin
                        BUSY_line_SLAVE <= 1'b0;
                        ERR             <= !addr_ok_q;
                        state           <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    BUSY_line_SLAVE <= 1'b0;
                    if (!BUSY_line_MASTER) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    BUSY_line_SLAVE <= 1'b0;
                    state           <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_code_store_responder.sv
// Two responders on one shared lane bus: A (DEPTH=16, RD_LAT=1) and B (DEPTH=256, RD_LAT=3).
module tb_code_store_responder;
    import code_store_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel_a, sel_b, m_addr, m_read, m_write, m_busy;
    logic        m_oe;
    logic [31:0] m_drv;
    wire  [7:0]  sa, sb, sc, ip;
    logic        busy_a, busy_b, err_a, err_b;
    state_t      st_a, st_b;
    logic [31:0] got;
    int          n_checks = 0;
    int          n_fail   = 0;

    assign sa = m_oe ? m_drv[31:24] : 'z;
    assign sb = m_oe ? m_drv[23:16] : 'z;
    assign sc = m_oe ? m_drv[15:8]  : 'z;
    assign ip = m_oe ? m_drv[7:0]   : 'z;

    always #5 clk = ~clk;

    code_store_responder #(.LEN_SEGMENT(8), .DEPTH(16), .RD_LAT(1)) dut_a (
        .CLK_B(clk), .RESET(rst), .SEL(sel_a), .ADDR(m_addr), .READ(m_read), .WRITE(m_write),
        .BUSY_line_MASTER(m_busy), .BUSY_line_SLAVE(busy_a),
        .SA_D3(sa), .SB_D2(sb), .SC_D1(sc), .IP_D0(ip), .ERR(err_a), .state_dbg(st_a)
    );

    code_store_responder #(.LEN_SEGMENT(8), .DEPTH(256), .RD_LAT(3)) dut_b (
        .CLK_B(clk), .RESET(rst), .SEL(sel_b), .ADDR(m_addr), .READ(m_read), .WRITE(m_write),
        .BUSY_line_MASTER(m_busy), .BUSY_line_SLAVE(busy_b),
        .SA_D3(sa), .SB_D2(sb), .SC_D1(sc), .IP_D0(ip), .ERR(err_b), .state_dbg(st_b)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        sel_a = 1'b0; sel_b = 1'b0; m_addr = 1'b0; m_read = 1'b0; m_write = 1'b0;
        m_busy = 1'b0; m_oe = 1'b0; m_drv = '0;
    endtask

    task automatic addr_phase(input bit to_b, input bit rd, input bit wr, input logic [7:0] a);
        sel_a = !to_b; sel_b = to_b; m_busy = 1'b1; m_addr = 1'b1;
        m_read = rd; m_write = wr; m_oe = 1'b1; m_drv = {24'h0, a};
    endtask

    task automatic write_word(input bit to_b, input logic [7:0] a, input logic [31:0] d);
        addr_phase(to_b, 1'b0, 1'b1, a);
        cyc();
        m_addr = 1'b0; m_drv = d;
        cyc();
        bus_idle();
        cyc();
    endtask

    // Returns the lane word seen in the first DRIVE cycle.
    task automatic read_word(input bit to_b, input logic [7:0] a, output logic [31:0] d);
        addr_phase(to_b, 1'b1, 1'b0, a);
        cyc();
        m_addr = 1'b0; m_read = 1'b0; m_oe = 1'b0;
        repeat (to_b ? 3 : 1) cyc();
        d = {sa, sb, sc, ip};
        m_busy = 1'b0;
        cyc();
        bus_idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_idle();
        repeat (2) cyc();
        n_checks++; if (st_a !== ST_IDLE) begin n_fail++; $display("FAIL rst_state_a: got %0d expected %0d", st_a, ST_IDLE); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_busy_a: got %b expected 0", busy_a); end
        n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL rst_err_a: got %b expected 0", err_a); end
        n_checks++; if (st_b !== ST_IDLE) begin n_fail++; $display("FAIL rst_state_b: got %0d expected %0d", st_b, ST_IDLE); end
        n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL rst_busy_b: got %b expected 0", busy_b); end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_write_read();
        addr_phase(1'b0, 1'b0, 1'b1, 8'h05);
        cyc();
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL wr_busy_set: got %b expected 1", busy_a); end
        n_checks++; if (st_a !== ST_WCAP) begin n_fail++; $display("FAIL wr_state_wcap: got %0d expected %0d", st_a, ST_WCAP); end
        m_addr = 1'b0; m_drv = 32'hDEAD_BEEF;
        cyc();
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL wr_busy_clr: got %b expected 0", busy_a); end
        n_checks++; if (st_a !== ST_RELEASE) begin n_fail++; $display("FAIL wr_state_rel: got %0d expected %0d", st_a, ST_RELEASE); end
        n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b expected 0", err_a); end
        bus_idle();
        cyc();
        n_checks++; if (st_a !== ST_IDLE) begin n_fail++; $display("FAIL wr_state_idle: got %0d expected %0d", st_a, ST_IDLE); end

        addr_phase(1'b0, 1'b1, 1'b0, 8'h05);
        cyc();
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL rd_busy_set: got %b expected 1", busy_a); end
        n_checks++; if (st_a !== ST_RWAIT) begin n_fail++; $display("FAIL rd_state_rwait: got %0d expected %0d", st_a, ST_RWAIT); end
        m_addr = 1'b0; m_read = 1'b0; m_oe = 1'b0;
        cyc();
        n_checks++; if (sa !== 8'hDE) begin n_fail++; $display("FAIL rd_sa: got %h expected de", sa); end
        n_checks++; if (sb !== 8'hAD) begin n_fail++; $display("FAIL rd_sb: got %h expected ad", sb); end
        n_checks++; if (sc !== 8'hBE) begin n_fail++; $display("FAIL rd_sc: got %h expected be", sc); end
        n_checks++; if (ip !== 8'hEF) begin n_fail++; $display("FAIL rd_ip: got %h expected ef", ip); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rd_busy_clr: got %b expected 0", busy_a); end
        m_busy = 1'b0;
        cyc();
        n_checks++; if (st_a !== ST_IDLE) begin n_fail++; $display("FAIL rd_state_idle: got %0d expected %0d", st_a, ST_IDLE); end
        m_oe = 1'b1; m_drv = '0;
        #1;
        n_checks++; if ({sa, sb, sc, ip} !== 32'h0) begin n_fail++; $display("FAIL rd_lanes_released: got %h expected 00000000", {sa, sb, sc, ip}); end
        bus_idle();
    endtask

    task automatic test_latency();
        write_word(1'b1, 8'h00, 32'hCAFE_F00D);
        addr_phase(1'b1, 1'b1, 1'b0, 8'h00);
        cyc();
        m_addr = 1'b0; m_read = 1'b0; m_oe = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            n_checks++; if (busy_b !== 1'b1) begin n_fail++; $display("FAIL lat_busy_c%0d: got %b expected 1", i, busy_b); end
            cyc();
        end
        n_checks++; if (busy_b !== 1'b1) begin n_fail++; $display("FAIL lat_busy_c3: got %b expected 1", busy_b); end
        n_checks++; if (st_b !== ST_RWAIT) begin n_fail++; $display("FAIL lat_state_rwait: got %0d expected %0d", st_b, ST_RWAIT); end
        cyc();
        n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL lat_busy_end: got %b expected 0", busy_b); end
        n_checks++; if ({sa, sb, sc, ip} !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL lat_data: got %h expected cafef00d", {sa, sb, sc, ip}); end
        repeat (2) cyc();
        n_checks++; if ({sa, sb, sc, ip} !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL lat_data_held: got %h expected cafef00d", {sa, sb, sc, ip}); end
        n_checks++; if (st_b !== ST_DRIVE) begin n_fail++; $display("FAIL lat_state_drive: got %0d expected %0d", st_b, ST_DRIVE); end
        m_busy = 1'b0;
        cyc();
        n_checks++; if (st_b !== ST_IDLE) begin n_fail++; $display("FAIL lat_state_idle: got %0d expected %0d", st_b, ST_IDLE); end
        bus_idle();
    endtask

    task automatic test_protocol_error();
        addr_phase(1'b0, 1'b1, 1'b1, 8'h05);
        cyc();
        n_checks++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL perr_err: got %b expected 1", err_a); end
        n_checks++; if (st_a !== ST_RELEASE) begin n_fail++; $display("FAIL perr_state: got %0d expected %0d", st_a, ST_RELEASE); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL perr_busy: got %b expected 0", busy_a); end
        m_addr = 1'b0; m_read = 1'b0; m_write = 1'b0; m_drv = '0;
        cyc();
        n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL perr_pulse: got %b expected 0", err_a); end
        n_checks++; if ({sa, sb, sc, ip} !== 32'h0) begin n_fail++; $display("FAIL perr_no_drive: got %h expected 00000000", {sa, sb, sc, ip}); end
        n_checks++; if (st_a !== ST_RELEASE) begin n_fail++; $display("FAIL perr_hold: got %0d expected %0d", st_a, ST_RELEASE); end
        m_busy = 1'b0;
        cyc();
        n_checks++; if (st_a !== ST_IDLE) begin n_fail++; $display("FAIL perr_idle: got %0d expected %0d", st_a, ST_IDLE); end
        bus_idle();
    endtask

    task automatic test_out_of_range();
        write_word(1'b0, 8'h00, 32'h0BAD_F00D);
        addr_phase(1'b0, 1'b1, 1'b0, 8'h20);
        cyc();
        m_addr = 1'b0; m_read = 1'b0; m_oe = 1'b0;
        cyc();
        n_checks++; if (st_a !== ST_DRIVE) begin n_fail++; $display("FAIL oor_rd_state: got %0d expected %0d", st_a, ST_DRIVE); end
        n_checks++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL oor_rd_err: got %b expected 1", err_a); end
        n_checks++; if ({sa, sb, sc, ip} !== 32'h0) begin n_fail++; $display("FAIL oor_rd_data: got %h expected 00000000", {sa, sb, sc, ip}); end
        cyc();
        n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL oor_rd_pulse: got %b expected 0", err_a); end
        m_busy = 1'b0;
        cyc();
        bus_idle();

        addr_phase(1'b0, 1'b0, 1'b1, 8'h20);
        cyc();
        m_addr = 1'b0; m_drv = 32'h1122_3344;
        cyc();
        n_checks++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL oor_wr_err: got %b expected 1", err_a); end
        bus_idle();
        cyc();
        read_word(1'b0, 8'h00, got);
        n_checks++; if (got !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL oor_wr_mem0: got %h expected 0badf00d", got); end
    endtask

    task automatic test_abort();
        write_word(1'b0, 8'h03, 32'h3333_3333);
        addr_phase(1'b0, 1'b0, 1'b1, 8'h03);
        cyc();
        n_checks++; if (st_a !== ST_WCAP) begin n_fail++; $display("FAIL abort_wcap: got %0d expected %0d", st_a, ST_WCAP); end
        m_addr = 1'b0; m_busy = 1'b0; m_drv = 32'h4444_4444;
        cyc();
        n_checks++; if (st_a !== ST_IDLE) begin n_fail++; $display("FAIL abort_idle: got %0d expected %0d", st_a, ST_IDLE); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy_a); end
        n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL abort_err: got %b expected 0", err_a); end
        bus_idle();
        cyc();
        read_word(1'b0, 8'h03, got);
        n_checks++; if (got !== 32'h3333_3333) begin n_fail++; $display("FAIL abort_mem: got %h expected 33333333", got); end
    endtask

    task automatic test_sel_gating();
        addr_phase(1'b0, 1'b1, 1'b0, 8'h05);
        sel_a = 1'b0; sel_b = 1'b0;
        cyc();
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL sel_busy_a: got %b expected 0", busy_a); end
        n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL sel_busy_b: got %b expected 0", busy_b); end
        n_checks++; if (st_a !== ST_IDLE) begin n_fail++; $display("FAIL sel_state_a: got %0d expected %0d", st_a, ST_IDLE); end
        m_addr = 1'b0; m_read = 1'b0; m_drv = 32'h0000_0005;
        cyc();
        n_checks++; if ({sa, sb, sc, ip} !== 32'h0000_0005) begin n_fail++; $display("FAIL sel_lanes: got %h expected 00000005", {sa, sb, sc, ip}); end
        bus_idle();
        cyc();
    endtask

    task automatic test_reset_mid_drive();
        addr_phase(1'b0, 1'b1, 1'b0, 8'h05);
        cyc();
        m_addr = 1'b0; m_read = 1'b0; m_oe = 1'b0;
        cyc();
        n_checks++; if ({sa, sb, sc, ip} !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rstd_pre_data: got %h expected deadbeef", {sa, sb, sc, ip}); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (st_a !== ST_IDLE) begin n_fail++; $display("FAIL rstd_state: got %0d expected %0d", st_a, ST_IDLE); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rstd_busy: got %b expected 0", busy_a); end
        m_oe = 1'b1; m_drv = '0;
        #1;
        n_checks++; if ({sa, sb, sc, ip} !== 32'h0) begin n_fail++; $display("FAIL rstd_lanes: got %h expected 00000000", {sa, sb, sc, ip}); end
        m_oe = 1'b0;
        rst = 1'b0;
        cyc();
        n_checks++; if (st_a !== ST_IDLE) begin n_fail++; $display("FAIL rstd_after: got %0d expected %0d", st_a, ST_IDLE); end
        bus_idle();
        cyc();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_latency();
        test_protocol_error();
        test_out_of_range();
        test_abort();
        test_sel_gating();
        test_reset_mid_drive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
